// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder_pkg
//  Description : Shared widths and FSM state encoding for the data-memory
//                responder and its backing array.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

    localparam int unsigned DMEM_ADDR_LEN = 32;
    localparam int unsigned DMEM_DATA_LEN = 32;
    localparam int unsigned DMEM_BE_LEN   = 4;
    localparam int unsigned DMEM_CNT_LEN  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : Word array with byte-lane write enables, synchronous write,
//                combinational read and asynchronous clear of every word.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned DATA_LEN    = DMEM_DATA_LEN,
    parameter int unsigned IDX_LEN     = $clog2(DEPTH_WORDS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [IDX_LEN-1:0]     wr_idx,
    input  logic [DATA_LEN-1:0]    wr_data,
    input  logic [DMEM_BE_LEN-1:0] wr_be,
    input  logic [IDX_LEN-1:0]     rd_idx,
    output logic [DATA_LEN-1:0]    rd_data
);

    logic [DATA_LEN-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < int'(DEPTH_WORDS); w++) begin
                r_mem[w] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < int'(DMEM_BE_LEN); b++) begin
                if (wr_be[b]) begin
                    r_mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = r_mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Handshake data-memory responder: accepts one request, waits
//                LATENCY cycles, performs the access and holds the response.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned ADDR_LEN    = DMEM_ADDR_LEN,
    parameter int unsigned DATA_LEN    = DMEM_DATA_LEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_LEN-1:0]    req_addr,
    input  logic [DATA_LEN-1:0]    req_wdata,
    input  logic [DMEM_BE_LEN-1:0] req_be,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DATA_LEN-1:0]    resp_rdata,
    output logic                   resp_err
);

    localparam int unsigned IDX_LEN = $clog2(DEPTH_WORDS);
    localparam logic [DMEM_CNT_LEN-1:0] C_CNT_LAST =
        DMEM_CNT_LEN'((LATENCY == 0) ? 0 : LATENCY - 1);

    state_t                   r_state, w_state_nxt;
    logic [DMEM_CNT_LEN-1:0]  r_cnt, w_cnt_nxt;

    logic                     r_we;
    logic [ADDR_LEN-1:0]      r_addr;
    logic [DATA_LEN-1:0]      r_wdata;
    logic [DMEM_BE_LEN-1:0]   r_be;
    logic [DATA_LEN-1:0]      r_rdata;
    logic                     r_err;

    logic                     w_accept;
    logic                     w_in_idle;
    logic                     w_enter_resp;
    logic                     w_acc_we;
    logic [ADDR_LEN-1:0]      w_acc_addr;
    logic [DATA_LEN-1:0]      w_acc_wdata;
    logic [DMEM_BE_LEN-1:0]   w_acc_be;
    logic                     w_acc_err;
    logic                     w_wr_en;
    logic [DATA_LEN-1:0]      w_rd_data;

    assign w_in_idle = (r_state == ST_IDLE);
    assign req_ready = w_in_idle && !rst;
    assign w_accept  = req_valid && req_ready;

    // With zero latency the access shares the accept edge, so it must see the
    // live request rather than the holding registers.
    assign w_acc_we    = w_in_idle ? req_we    : r_we;
    assign w_acc_addr  = w_in_idle ? req_addr  : r_addr;
    assign w_acc_wdata = w_in_idle ? req_wdata : r_wdata;
    assign w_acc_be    = w_in_idle ? req_be    : r_be;

    assign w_acc_err = (w_acc_addr[1:0] != 2'b00) ||
                       ((w_acc_addr >> (IDX_LEN + 2)) != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (LATENCY == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_enter_resp = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);
    assign w_wr_en      = w_enter_resp && w_acc_we && !w_acc_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_LEN    (DATA_LEN),
        .IDX_LEN     (IDX_LEN)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en),
        .wr_idx  (w_acc_addr[IDX_LEN+1:2]),
        .wr_data (w_acc_wdata),
        .wr_be   (w_acc_be),
        .rd_idx  (w_acc_addr[IDX_LEN+1:2]),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
            end
            if (w_enter_resp) begin
                r_rdata <= (w_acc_we || w_acc_err) ? '0 : w_rd_data;
                r_err   <= w_acc_err;
            end else if ((r_state == ST_RESP) && resp_ready) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
`default_nettype wire
